// File: rtl/tone_pkg.sv
// Shared constants for the note tone generator: note word width,
// minimum half-period and FSM state encoding.
package tone_pkg;

  // Note word width, matching the note memory data width.
  localparam int NOTE_W = 27;

  // Shortest half-period allowed; nonzero notes below this are raised to it.
  localparam int MIN_HALF = 2;

  // FSM state encoding. 2'd3 is unreachable and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/note_tone_gen_half_cycle_counter.sv
// Loadable down-counter used to time each half of the square wave.
// Load wins over decrement; the count holds at zero.
module half_cycle_counter #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Count register: clear on reset, load a new half length, or count down.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator. The note word is a half-period in clk
// cycles (0 = rest). New notes and mute are only honoured at the end of
// a full period, so the output never carries a truncated half-cycle.
module note_tone_gen #(
  parameter int NOTE_W   = tone_pkg::NOTE_W,
  parameter int MIN_HALF = tone_pkg::MIN_HALF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note,
  input  logic              mute,
  output logic              audio,
  output logic              playing,
  output logic              period_tick
);

  import tone_pkg::*;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [NOTE_W-1:0] note_q_reg;
  logic [NOTE_W-1:0] cur_half_reg;
  logic [NOTE_W-1:0] cur_half_next;
  logic [NOTE_W-1:0] eff;
  logic              cnt_load;
  logic [NOTE_W-1:0] cnt_load_val;
  logic              cnt_en;
  logic              cnt_zero;

  // Nonzero notes shorter than the minimum are raised to the minimum.
  assign eff = (note_q_reg < NOTE_W'(MIN_HALF)) ? NOTE_W'(MIN_HALF) : note_q_reg;

  half_cycle_counter #(
    .W(NOTE_W)
  ) u_half_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Next-state logic: notes are sampled only from IDLE or at the LOW-half end.
  always_comb begin
    state_next    = state_reg;
    cur_half_next = cur_half_reg;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_en        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if ((note_q_reg != '0) && !mute) begin
          cur_half_next = eff;
          cnt_load      = 1'b1;
          cnt_load_val  = eff - 1'b1;
          state_next    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = cur_half_reg - 1'b1;
          state_next   = ST_LOW;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (mute || (note_q_reg == '0)) begin
          state_next = ST_IDLE;
        end else begin
          cur_half_next = eff;
          cnt_load      = 1'b1;
          cnt_load_val  = eff - 1'b1;
          state_next    = ST_HIGH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, half-length and note input registers; reset abandons any period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cur_half_reg <= '0;
      note_q_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cur_half_reg <= cur_half_next;
      note_q_reg   <= note;
    end
  end

  // Outputs decode straight from the state register, so audio is glitch-free.
  assign audio       = (state_reg == ST_HIGH);
  assign playing     = (state_reg != ST_IDLE);
  assign period_tick = (state_reg == ST_LOW) && cnt_zero;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: drives hand-written note/mute/reset
// sequences and checks the output waveform cycle by cycle.
module tb_note_tone_gen;

  logic        clk;
  logic        reset;
  logic [26:0] note;
  logic        mute;
  logic        audio;
  logic        playing;
  logic        period_tick;

  int pass_cnt;
  int total_cnt;

  note_tone_gen dut (
    .clk         (clk),
    .reset       (reset),
    .note        (note),
    .mute        (mute),
    .audio       (audio),
    .playing     (playing),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_out(input string tag, input logic a, input logic p, input logic t);
    chk({tag, ".audio"}, audio, a);
    chk({tag, ".playing"}, playing, p);
    chk({tag, ".tick"}, period_tick, t);
    $display("%0t %s audio=%b playing=%b tick=%b", $time, tag, audio, playing, period_tick);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic high_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag, 1'b1, 1'b1, 1'b0);
    end
  endtask

  // LOW half; tick expected only on the final cycle when tick_last is set.
  task automatic low_cycles(input string tag, input int n, input logic tick_last);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag, 1'b0, 1'b1, (i == n - 1) ? tick_last : 1'b0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    note      = 27'd5;
    mute      = 1'b0;

    // Reset held for 3 cycles with a nonzero note: everything stays quiet.
    idle_cycles("rst_hold", 3);
    // Release with note=3: one idle cycle, then 3 high / 3 low repeating.
    reset = 1'b1;
    note  = 27'd3;
    idle_cycles("rel_idle", 1);
    high_cycles("n3_h1", 3);
    low_cycles("n3_l1", 3, 1'b1);
    high_cycles("n3_h2", 3);
    low_cycles("n3_l2", 3, 1'b1);

    // Note change during the 2nd HIGH cycle waits for the period boundary.
    apply_reset();
    reset = 1'b1;
    note  = 27'd3;
    idle_cycles("chg_idle", 1);
    high_cycles("chg_h3a", 2);
    note = 27'd5;
    high_cycles("chg_h3b", 1);
    low_cycles("chg_l3", 3, 1'b1);
    high_cycles("chg_h5", 5);
    low_cycles("chg_l5", 5, 1'b1);

    // note=1 is clamped up to a 2/2 period.
    apply_reset();
    reset = 1'b1;
    note  = 27'd1;
    idle_cycles("n1_idle", 1);
    high_cycles("n1_h1", 2);
    low_cycles("n1_l1", 2, 1'b1);
    high_cycles("n1_h2", 2);
    low_cycles("n1_l2", 2, 1'b1);

    // note=0 from reset: remains idle.
    apply_reset();
    reset = 1'b1;
    note  = 27'd0;
    idle_cycles("n0_idle", 4);

    // Rest requested on the 1st HIGH cycle: full 4/4 period, then idle.
    apply_reset();
    reset = 1'b1;
    note  = 27'd4;
    idle_cycles("rest_idle", 1);
    high_cycles("rest_h1", 1);
    note = 27'd0;
    high_cycles("rest_h2", 3);
    low_cycles("rest_l", 4, 1'b1);
    idle_cycles("rest_end", 2);

    // Mute raised mid-LOW: period completes, then idle while muted.
    apply_reset();
    reset = 1'b1;
    note  = 27'd4;
    idle_cycles("mute_idle", 1);
    high_cycles("mute_h", 4);
    low_cycles("mute_la", 2, 1'b0);
    mute = 1'b1;
    low_cycles("mute_lb", 2, 1'b1);
    idle_cycles("mute_hold", 3);
    // Mute dropped: IDLE sees it at the next edge and restarts HIGH.
    mute = 1'b0;
    high_cycles("unmute_h", 4);
    low_cycles("unmute_l", 4, 1'b1);

    // Reset mid-HIGH of note=6 abandons the period immediately.
    apply_reset();
    reset = 1'b1;
    note  = 27'd6;
    idle_cycles("rmid_idle", 1);
    high_cycles("rmid_h", 3);
    reset = 1'b0;
    idle_cycles("rmid_rst", 1);
    // After release, a fresh full 6/6 period with no leftover count.
    reset = 1'b1;
    idle_cycles("rmid_rel", 1);
    high_cycles("rmid_h6", 6);
    low_cycles("rmid_l6", 6, 1'b1);
    high_cycles("rmid_h6b", 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
